// File: rtl/fault_check_sched.sv
// fault_check_sched: sequencer for an external combinational posit-add fault checker.
// Accepts operand pairs, holds them on chk_a/chk_b for SETTLE_CYC cycles, samples the
// checker and presents the selected sum on a valid/ready output stream.
// Optional statistics counters are built only when FCS_STATS_EN is defined.
module fault_check_sched #(
  parameter int unsigned FULL_NBITS  = 32,
  parameter int unsigned TRUNC_NBITS = 16,
  parameter int unsigned ES          = 2,
  parameter int unsigned FRAC_SIZE   = 3,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FULL_NBITS-1:0] in_a,
  input  logic [FULL_NBITS-1:0] in_b,
  output logic [FULL_NBITS-1:0] chk_a,
  output logic [FULL_NBITS-1:0] chk_b,
  input  logic                  chk_fault,
  input  logic                  chk_mode,
  input  logic [FULL_NBITS-1:0] chk_true_sum,
  input  logic [FULL_NBITS-1:0] chk_used_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULL_NBITS-1:0] out_sum,
  output logic                  out_fault,
  output logic                  out_mode,
  output logic                  busy,
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      op_count,
  output logic [CNT_W-1:0]      fault_count
);

  localparam int unsigned SCNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [SCNT_W-1:0] scnt;
  logic [SCNT_W-1:0] scnt_nxt;
  logic              load_c;
  logic              sample_c;

  // Checker geometry parameters are only forwarded by the integrator; sink them here.
  logic unused_cfg;
`ifdef FCS_STATS_EN
  assign unused_cfg = ^{32'(TRUNC_NBITS), 32'(ES), 32'(FRAC_SIZE)};
`else
  assign unused_cfg = ^{32'(TRUNC_NBITS), 32'(ES), 32'(FRAC_SIZE), stat_clr};
`endif

  // State and settle-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in SETTLE, wait for consumer in HOLD.
  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    load_c    = 1'b0;
    sample_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          load_c    = 1'b1;
          scnt_nxt  = SCNT_W'(SETTLE_CYC - 1);
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (scnt != '0) begin
          scnt_nxt = scnt - SCNT_W'(1);
        end else begin
          sample_c  = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status outputs registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_HOLD);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  // Operand hold registers feeding the checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_a <= '0;
      chk_b <= '0;
    end else if (load_c) begin
      chk_a <= in_a;
      chk_b <= in_b;
    end
  end

  // Result capture: full-precision sum when the checker flags a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_fault <= 1'b0;
      out_mode  <= 1'b0;
    end else if (sample_c) begin
      out_sum   <= chk_fault ? chk_true_sum : chk_used_sum;
      out_fault <= chk_fault;
      out_mode  <= chk_mode;
    end
  end

`ifdef FCS_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= '0;
      fault_count <= '0;
    end else if (stat_clr) begin
      op_count    <= '0;
      fault_count <= '0;
    end else if (sample_c) begin
      if (op_count != CNT_MAX) begin
        op_count <= op_count + CNT_W'(1);
      end
      if (chk_fault && (fault_count != CNT_MAX)) begin
        fault_count <= fault_count + CNT_W'(1);
      end
    end
  end
`else
  assign op_count    = '0;
  assign fault_count = '0;
`endif

endmodule
